// File: rtl/mem_stage_dmem_if.sv
// mem_stage_dmem_if: MEM-stage data-memory access unit with a req/ack bus, big-endian
// lane alignment for stores and loads, and a bounded wait that aborts on timeout.
`default_nettype none

module mem_stage_dmem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRd_In,
  input  logic        MemWr_In,
  input  logic [1:0]  Size_In,
  input  logic        Sign_Ext_In,
  input  logic [31:0] ALU_Res_In,
  input  logic [31:0] WD_In,
  input  logic        Bus_Ack,
  input  logic [31:0] Bus_RD,
  output logic        Bus_Req,
  output logic        Bus_WE,
  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WD,
  output logic [3:0]  Bus_BE,
  output logic [31:0] RD_DM_Out,
  output logic        Stall_Out,
  output logic        Misalign_Out,
  output logic        Bus_Err_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        access, word_sz, misaligned, req;
  logic        stall, bus_req, timeout;
  logic [3:0]  st_be;
  logic [31:0] st_wd, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic [31:0] addr_q, wd_q, rd_dm;
  logic [3:0]  be_q;
  logic [1:0]  size_q, lane_q;
  logic        we_q, sign_q, bus_err;
  logic [7:0]  cnt;

  assign access     = MemRd_In | MemWr_In;
  assign word_sz    = (Size_In == 2'b00) || (Size_In == 2'b11);
  assign misaligned = word_sz ? (|ALU_Res_In[1:0]) :
                      (Size_In == 2'b01) ? ALU_Res_In[0] : 1'b0;
  assign req        = access & ~misaligned;

  // Lane 0 is the most significant byte (big-endian).
  always_comb begin
    st_be = 4'b1111;
    st_wd = WD_In;
    if (Size_In == 2'b01) begin
      st_be = ALU_Res_In[1] ? 4'b0011 : 4'b1100;
      st_wd = {2{WD_In[15:0]}};
    end else if (Size_In == 2'b10) begin
      st_be = 4'b1000 >> ALU_Res_In[1:0];
      st_wd = {4{WD_In[7:0]}};
    end
  end

  always_comb begin
    ld_half = lane_q[1] ? Bus_RD[15:0] : Bus_RD[31:16];
    case (lane_q)
      2'd0:    ld_byte = Bus_RD[31:24];
      2'd1:    ld_byte = Bus_RD[23:16];
      2'd2:    ld_byte = Bus_RD[15:8];
      default: ld_byte = Bus_RD[7:0];
    endcase
    case (size_q)
      2'b10:   ld_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sign_q & ld_half[15]}}, ld_half};
      default: ld_data = Bus_RD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    bus_req   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        // A late Ack in the last allowed cycle still completes normally.
        if (Bus_Ack) begin
          state_nxt = DONE;
        end else if (cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      cnt     <= '0;
      rd_dm   <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout;
      if (state == IDLE && req) begin
        addr_q <= {ALU_Res_In[31:2], 2'b00};
        lane_q <= ALU_Res_In[1:0];
        we_q   <= MemWr_In;
        wd_q   <= st_wd;
        be_q   <= st_be;
        size_q <= Size_In;
        sign_q <= Sign_Ext_In;
        cnt    <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
        if (Bus_Ack) begin
          if (!we_q) rd_dm <= ld_data;
        end else if (timeout) begin
          rd_dm <= '0;
        end
      end
    end
  end

  // Comb outputs are gated by RST so every output reads 0 while reset is held.
  assign Bus_Req      = bus_req;
  assign Stall_Out    = stall & ~RST;
  assign Misalign_Out = (state == IDLE) & access & misaligned & ~RST;
  assign Bus_WE       = we_q;
  assign Bus_Addr     = addr_q;
  assign Bus_WD       = wd_q;
  assign Bus_BE       = be_q;
  assign RD_DM_Out    = rd_dm;
  assign Bus_Err_Out  = bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_dmem_if.sv
// tb_mem_stage_dmem_if: scoreboard bench for mem_stage_dmem_if with a short timeout setting.
`default_nettype none

module tb_mem_stage_dmem_if;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  be;
  } bus_exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRd_In, MemWr_In, Sign_Ext_In, Bus_Ack;
  logic [1:0]  Size_In;
  logic [31:0] ALU_Res_In, WD_In, Bus_RD;
  logic        Bus_Req, Bus_WE, Stall_Out, Misalign_Out, Bus_Err_Out;
  logic [31:0] Bus_Addr, Bus_WD, RD_DM_Out;
  logic [3:0]  Bus_BE;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rd_dm_model = '0;
  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];

  mem_stage_dmem_if #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .MemRd_In(MemRd_In), .MemWr_In(MemWr_In), .Size_In(Size_In),
    .Sign_Ext_In(Sign_Ext_In), .ALU_Res_In(ALU_Res_In), .WD_In(WD_In),
    .Bus_Ack(Bus_Ack), .Bus_RD(Bus_RD),
    .Bus_Req(Bus_Req), .Bus_WE(Bus_WE), .Bus_Addr(Bus_Addr), .Bus_WD(Bus_WD),
    .Bus_BE(Bus_BE), .RD_DM_Out(RD_DM_Out), .Stall_Out(Stall_Out),
    .Misalign_Out(Misalign_Out), .Bus_Err_Out(Bus_Err_Out)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] a, input logic [31:0] d);
    logic [31:0] s;
    case (sz)
      2'b10: begin
        s = d >> (8 * (3 - int'(a)));
        return {{24{sx & s[7]}}, s[7:0]};
      end
      2'b01: begin
        s = a[1] ? d : (d >> 16);
        return {{16{sx & s[15]}}, s[15:0]};
      end
      default: return d;
    endcase
  endfunction

  function automatic bus_exp_t exp_bus(input logic wr, input logic [1:0] sz,
                                       input logic [31:0] a, input logic [31:0] wd);
    bus_exp_t e;
    e.addr = {a[31:2], 2'b00};
    e.we   = wr;
    case (sz)
      2'b01:   begin e.be = a[1] ? 4'b0011 : 4'b1100; e.wd = {wd[15:0], wd[15:0]}; end
      2'b10:   begin e.be = 4'b1000 >> a[1:0]; e.wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
      default: begin e.be = 4'b1111; e.wd = wd; end
    endcase
    return e;
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ack_dly);
    int       stalls;
    int       cyc;
    bus_exp_t e;
    @(negedge CLK);
    MemRd_In = rd; MemWr_In = wr; Size_In = sz; Sign_Ext_In = sx;
    ALU_Res_In = addr; WD_In = wd;
    bus_q.push_back(exp_bus(wr, sz, addr, wd));
    if (!wr) rd_dm_model = exp_load(sz, sx, addr[1:0], rdata);
    rd_q.push_back(rd_dm_model);
    #1;
    stalls = Stall_Out ? 1 : 0;
    check_eq("idle_misalign", {31'd0, Misalign_Out}, 32'd0);
    @(negedge CLK);
    MemRd_In = 1'b0; MemWr_In = 1'b0;
    ALU_Res_In = $urandom; WD_In = $urandom; Size_In = 2'($urandom); Sign_Ext_In = 1'($urandom);
    cyc = 0;
    while (!Bus_Req && cyc < 8) begin @(negedge CLK); cyc++; end
    e = bus_q.pop_front();
    check_eq("bus_req", {31'd0, Bus_Req}, 32'd1);
    check_eq("bus_addr", Bus_Addr, e.addr);
    check_eq("bus_we", {31'd0, Bus_WE}, {31'd0, e.we});
    check_eq("bus_wd", Bus_WD, e.wd);
    check_eq("bus_be", {28'd0, Bus_BE}, {28'd0, e.be});
    repeat (ack_dly) begin
      stalls += Stall_Out ? 1 : 0;
      @(negedge CLK);
      check_eq("bus_addr_hold", Bus_Addr, e.addr);
    end
    stalls += Stall_Out ? 1 : 0;
    Bus_Ack = 1'b1; Bus_RD = rdata;
    @(negedge CLK);
    Bus_Ack = 1'b0; Bus_RD = $urandom;
    check_eq("stall_cycles", stalls, 2 + ack_dly);
    check_eq("done_stall", {31'd0, Stall_Out}, 32'd0);
    check_eq("done_req", {31'd0, Bus_Req}, 32'd0);
    check_eq("rd_dm", RD_DM_Out, rd_q.pop_front());
  endtask

  task automatic misalign(input logic [1:0] sz, input logic [31:0] addr);
    @(negedge CLK);
    MemRd_In = 1'b1; Size_In = sz; ALU_Res_In = addr;
    #1;
    check_eq("misalign", {31'd0, Misalign_Out}, 32'd1);
    check_eq("misalign_stall", {31'd0, Stall_Out}, 32'd0);
    repeat (3) begin
      @(negedge CLK);
      check_eq("misalign_req", {31'd0, Bus_Req}, 32'd0);
    end
    check_eq("misalign_rd", RD_DM_Out, rd_dm_model);
    MemRd_In = 1'b0;
  endtask

  initial begin
    int n;
    RST = 1'b1;
    MemRd_In = 0; MemWr_In = 0; Size_In = 0; Sign_Ext_In = 0;
    ALU_Res_In = 0; WD_In = 0; Bus_Ack = 0; Bus_RD = 0;
    #3;
    check_eq("rst_req", {31'd0, Bus_Req}, 32'd0);
    check_eq("rst_stall", {31'd0, Stall_Out}, 32'd0);
    check_eq("rst_rd", RD_DM_Out, 32'd0);
    check_eq("rst_bus", {Bus_Addr[27:0], Bus_BE}, 32'd0);
    check_eq("rst_err", {30'd0, Bus_Err_Out, Bus_WE}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    access(1, 0, 2'b00, 0, 32'h0000_0100, 32'h0,         32'h1234_5678, 1);
    access(1, 0, 2'b10, 1, 32'h0000_0203, 32'h0,         32'h0000_00F0, 0);
    access(1, 0, 2'b10, 0, 32'h0000_0203, 32'h0,         32'h0000_00F0, 2);
    access(0, 1, 2'b01, 0, 32'h0000_0302, 32'hAAAA_BEEF, 32'h0,         0);
    access(1, 0, 2'b01, 1, 32'h0000_0402, 32'h0,         32'h1234_8001, 3);
    access(1, 0, 2'b01, 0, 32'h0000_0400, 32'h0,         32'h9ABC_1234, 0);
    access(1, 1, 2'b10, 0, 32'h0000_0501, 32'h1122_3344, 32'hFFFF_FFFF, 1);
    access(0, 1, 2'b00, 0, 32'h0000_0A04, 32'hDEAD_BEEF, 32'h0,         0);
    access(1, 0, 2'b11, 0, 32'h0000_0600, 32'h0,         32'hCAFE_F00D, 0);
    check_eq("lw_word_size3", RD_DM_Out, 32'hCAFE_F00D);

    misalign(2'b00, 32'h0000_0101);
    misalign(2'b01, 32'h0000_0403);

    // Unacknowledged load runs out the 4-cycle budget.
    @(negedge CLK);
    MemRd_In = 1'b1; Size_In = 2'b00; ALU_Res_In = 32'h0000_0700;
    rd_q.push_back(32'd0);
    @(negedge CLK);
    MemRd_In = 1'b0;
    n = 0;
    while (Bus_Req && n < 20) begin n++; @(negedge CLK); end
    check_eq("timeout_busy_cycles", n, 4);
    check_eq("timeout_err", {31'd0, Bus_Err_Out}, 32'd1);
    check_eq("timeout_rd", RD_DM_Out, rd_q.pop_front());
    check_eq("timeout_stall", {31'd0, Stall_Out}, 32'd0);
    rd_dm_model = 32'd0;
    @(negedge CLK);
    check_eq("timeout_err_pulse", {31'd0, Bus_Err_Out}, 32'd0);

    access(1, 0, 2'b00, 0, 32'h0000_0800, 32'h0, 32'h5555_AAAA, 0);

    // Reset while BUSY, then a stray Ack after release.
    @(negedge CLK);
    MemRd_In = 1'b1; Size_In = 2'b00; ALU_Res_In = 32'h0000_0900;
    @(negedge CLK);
    MemRd_In = 1'b0;
    check_eq("pre_rst_req", {31'd0, Bus_Req}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check_eq("async_rst_req", {31'd0, Bus_Req}, 32'd0);
    check_eq("async_rst_stall", {31'd0, Stall_Out}, 32'd0);
    check_eq("async_rst_rd", RD_DM_Out, 32'd0);
    rd_dm_model = 32'd0;
    @(negedge CLK);
    RST = 1'b0; Bus_Ack = 1'b1; Bus_RD = 32'hFFFF_FFFF;
    @(negedge CLK);
    Bus_Ack = 1'b0;
    check_eq("late_ack_req", {31'd0, Bus_Req}, 32'd0);
    check_eq("late_ack_stall", {31'd0, Stall_Out}, 32'd0);
    check_eq("late_ack_rd", RD_DM_Out, rd_dm_model);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
